layer4_window_fetch: RTL and testbench

Downstream read sequencer for the layer-3 result memory, which holds a 14×14 map of 128-bit pixels at address row*14+col. It drives that memory's read port (row/col address and read strobe) and builds sliding 3×3 windows (stride 1, no padding; 12×12 window positions) for the layer-4 convolution engine. Windows are delivered over a valid/ready handshake. Within a row, horizontal column reuse means only 3 new pixels are read per step.

---
 rtl/layer4_window_fetch_pkg.sv | 22 ++
 rtl/layer4_window_fetch_if.sv | 34 +++
 rtl/layer4_window_shift.sv | 51 +++++
 rtl/layer4_window_fetch.sv | 174 +++++++++++++++++
 tb/tb_layer4_window_fetch.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer4_window_fetch_pkg.sv
// Shared types and constants for the layer-4 3x3 window fetch sequencer.
package layer4_window_fetch_pkg;

  localparam int LAYER4_WIDTH         = 14;
  localparam int LAYER3_OUTPUT_LENGTH = 128;
  localparam int LAYER4_K             = 3;
  localparam int WINDOW_COUNT         = LAYER4_WIDTH - LAYER4_K + 1;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SLIDE,
    HOLD,
    DONE
  } state_t;

  // Last legal window origin along one axis of an in_w x in_w map.
  function automatic logic [15:0] last_pos(input int in_w, input int k);
    return 16'(in_w - k);
  endfunction

endpackage

// File: rtl/layer4_window_fetch_if.sv
// Memory read port plus window stream between the fetch sequencer and its environment.
interface layer4_window_fetch_if
  import layer4_window_fetch_pkg::*;
#(
  parameter int K      = LAYER4_K,
  parameter int DATA_W = LAYER3_OUTPUT_LENGTH
);

  logic                    start;
  logic [15:0]             read_row_addr;
  logic [15:0]             read_col_addr;
  logic                    layer3_result_read_signal;
  logic [DATA_W-1:0]       layer3_result_output;
  logic [K*K*DATA_W-1:0]   window_data;
  logic                    window_valid;
  logic                    window_ready;
  logic [15:0]             out_row;
  logic [15:0]             out_col;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, layer3_result_output, window_ready,
    output read_row_addr, read_col_addr, layer3_result_read_signal,
           window_data, window_valid, out_row, out_col, busy, done
  );

  modport slave (
    output start, layer3_result_output, window_ready,
    input  read_row_addr, read_col_addr, layer3_result_read_signal,
           window_data, window_valid, out_row, out_col, busy, done
  );

endinterface

// File: rtl/layer4_window_shift.sv
// K x K pixel register bank: per-slot load, column-left shift and synchronous clear.
module layer4_window_shift
  import layer4_window_fetch_pkg::*;
#(
  parameter int  K      = LAYER4_K,
  parameter int  DATA_W = LAYER3_OUTPUT_LENGTH,
  localparam int SLOTS  = K * K,
  localparam int SLOT_W = $clog2(SLOTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    shift_en,
  input  logic                    load_en,
  input  logic [SLOT_W-1:0]       load_slot,
  input  logic [DATA_W-1:0]       load_data,
  output logic [SLOTS*DATA_W-1:0] window_data
);

  logic [SLOTS-1:0][DATA_W-1:0] bank_q, bank_d;

  // Shift and load never coincide in practice, but a load still wins over a shifted value.
  always_comb begin
    bank_d = bank_q;
    if (clear) begin
      bank_d = '0;
    end else begin
      if (shift_en) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K - 1; j++) begin
            bank_d[i*K+j] = bank_q[i*K+j+1];
          end
        end
      end
      if (load_en) begin
        bank_d[load_slot] = load_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign window_data = bank_q;

endmodule

// File: rtl/layer4_window_fetch.sv
// Read sequencer for the layer-3 result map: builds stride-1 3x3 windows with column reuse.
module layer4_window_fetch
  import layer4_window_fetch_pkg::*;
#(
  parameter int IN_W   = LAYER4_WIDTH,
  parameter int K      = LAYER4_K,
  parameter int DATA_W = LAYER3_OUTPUT_LENGTH
) (
  input logic                  clk,
  input logic                  rst,
  layer4_window_fetch_if.master bus
);

  localparam int          SLOT_W      = $clog2(K * K);
  localparam logic [7:0]  FILL_READS  = 8'(K * K);
  localparam logic [7:0]  SLIDE_READS = 8'(K);
  localparam logic [15:0] LAST_POS    = last_pos(IN_W, K);
  localparam logic [15:0] K16         = 16'(K);

  state_t            state_q, state_d;
  logic [15:0]       r_q, r_d, c_q, c_d;
  logic [7:0]        k_q, k_d;
  logic [15:0]       row_q, row_d, col_q, col_d;
  logic              rd_q, rd_d;
  logic              cap_q, cap_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  logic              issue;
  logic [7:0]        issue_k;
  logic              shift_en;
  logic              clear;
  logic [15:0]       issue_i, issue_j;
  logic              win_valid, busy_o, done_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      rd_q    <= 1'b0;
      cap_q   <= 1'b0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rd_q    <= rd_d;
      cap_q   <= cap_d;
      slot_q  <= slot_d;
    end
  end

  // Leaving IDLE or HOLD launches the first read of the next fill/slide in the same edge,
  // so k_q counts reads already issued and the last capture coincides with entering HOLD.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    k_d      = k_q;
    issue    = 1'b0;
    issue_k  = k_q;
    shift_en = 1'b0;
    clear    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FILL;
          r_d     = '0;
          c_d     = '0;
          k_d     = 8'd1;
          issue   = 1'b1;
          issue_k = '0;
        end
      end
      FILL: begin
        if (k_q == FILL_READS) begin
          state_d = HOLD;
        end else begin
          issue = 1'b1;
          k_d   = k_q + 8'd1;
        end
      end
      SLIDE: begin
        if (k_q == SLIDE_READS) begin
          state_d = HOLD;
        end else begin
          issue = 1'b1;
          k_d   = k_q + 8'd1;
        end
      end
      HOLD: begin
        if (bus.window_ready) begin
          issue_k = '0;
          k_d     = 8'd1;
          issue   = 1'b1;
          if (c_q != LAST_POS) begin
            state_d  = SLIDE;
            c_d      = c_q + 16'd1;
            shift_en = 1'b1;
          end else if (r_q != LAST_POS) begin
            state_d = FILL;
            r_d     = r_q + 16'd1;
            c_d     = '0;
          end else begin
            state_d = DONE;
            issue   = 1'b0;
            k_d     = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        clear   = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fill reads walk the window column-major; slide reads only refill the rightmost column.
  always_comb begin
    if (state_d == FILL) begin
      issue_i = {8'd0, issue_k} % K16;
      issue_j = {8'd0, issue_k} / K16;
    end else begin
      issue_i = {8'd0, issue_k};
      issue_j = K16 - 16'd1;
    end
    rd_d   = issue;
    cap_d  = issue;
    row_d  = row_q;
    col_d  = col_q;
    slot_d = slot_q;
    if (issue) begin
      row_d  = r_d + issue_i;
      col_d  = c_d + issue_j;
      slot_d = SLOT_W'(issue_i * K16 + issue_j);
    end
    win_valid = (state_q == HOLD);
    busy_o    = (state_q != IDLE);
    done_o    = (state_q == DONE);
  end

  layer4_window_shift #(
    .K      (K),
    .DATA_W (DATA_W)
  ) u_shift (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .shift_en    (shift_en),
    .load_en     (cap_q),
    .load_slot   (slot_q),
    .load_data   (bus.layer3_result_output),
    .window_data (bus.window_data)
  );

  assign bus.read_row_addr             = row_q;
  assign bus.read_col_addr             = col_q;
  assign bus.layer3_result_read_signal = rd_q;
  assign bus.window_valid              = win_valid;
  assign bus.out_row                   = r_q;
  assign bus.out_col                   = c_q;
  assign bus.busy                      = busy_o;
  assign bus.done                      = done_o;

endmodule

// File: tb/tb_layer4_window_fetch.sv
// Bench for layer4_window_fetch: memory model pixel(row,col) = {row,col} x4, window scoreboard.
`timescale 1ns/1ps
module tb_layer4_window_fetch;
  import layer4_window_fetch_pkg::*;

  localparam int K            = LAYER4_K;
  localparam int DATA_W       = LAYER3_OUTPUT_LENGTH;
  localparam int IN_W         = LAYER4_WIDTH;
  localparam int NWIN         = WINDOW_COUNT;
  localparam int WBITS        = K * K * DATA_W;
  localparam int FRAME_BUDGET = 5000;

  localparam int MODE_FULL   = 0;
  localparam int MODE_STALL  = 1;
  localparam int MODE_INJECT = 2;
  localparam int MODE_RANDOM = 3;
  localparam int MODE_ABORT  = 4;

  typedef struct {
    int r;
    int c;
    int slot;
    int exp_row;
    int exp_col;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layer4_window_fetch_if #(.K(K), .DATA_W(DATA_W)) bus ();

  layer4_window_fetch #(.IN_W(IN_W), .K(K), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [DATA_W-1:0] pixel(input logic [15:0] row, input logic [15:0] col);
    return {4{row, col}};
  endfunction

  function automatic logic [WBITS-1:0] exp_window(input int r, input int c);
    logic [WBITS-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[(i*K+j)*DATA_W +: DATA_W] = pixel(16'(r + i), 16'(c + j));
    return w;
  endfunction

  assign bus.layer3_result_output = pixel(bus.read_row_addr, bus.read_col_addr);

  int vec_count;
  int miscompares;
  int first_valid_t, last_hs_t, done_t, end_t, done_count, nwin;
  bit aborted;
  vec_t vectors[9];
  logic [WBITS-1:0] store [NWIN*NWIN];

  task automatic applyStimulus(input logic s, input logic rdy);
    bus.start        = s;
    bus.window_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vec_count++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkPixel(input string name, input logic [DATA_W-1:0] actual,
                            input logic [DATA_W-1:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkWindow(input string name, input logic [WBITS-1:0] actual,
                             input logic [WBITS-1:0] expected);
    bit shown;
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      shown = 1'b0;
      for (int s = 0; s < K * K; s++) begin
        if (!shown && actual[s*DATA_W +: DATA_W] !== expected[s*DATA_W +: DATA_W]) begin
          shown = 1'b1;
          $display("[TB] FAIL %s slot %0d: got %h, expected %h", name, s,
                   actual[s*DATA_W +: DATA_W], expected[s*DATA_W +: DATA_W]);
        end
      end
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_read_row_addr"}, bus.read_row_addr, 0);
    checkOutput({tag, "_read_col_addr"}, bus.read_col_addr, 0);
    checkOutput({tag, "_read_signal"}, bus.layer3_result_read_signal, 0);
    checkOutput({tag, "_window_data_any"}, |bus.window_data, 0);
    checkOutput({tag, "_window_valid"}, bus.window_valid, 0);
    checkOutput({tag, "_out_row"}, bus.out_row, 0);
    checkOutput({tag, "_out_col"}, bus.out_col, 0);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_done"}, bus.done, 0);
  endtask

  task automatic applyVectors(input string tag);
    for (int v = 0; v < 9; v++) begin
      checkPixel($sformatf("%s_win%0d_%0d_slot%0d", tag, vectors[v].r, vectors[v].c, vectors[v].slot),
                 store[vectors[v].r*NWIN+vectors[v].c][vectors[v].slot*DATA_W +: DATA_W],
                 pixel(16'(vectors[v].exp_row), 16'(vectors[v].exp_col)));
    end
  endtask

  // Times are counted in rising edges after E0, the edge that samples start.
  task automatic runFrame(input int mode);
    int t, exp_r, exp_c, gap_reads, stall_left;
    logic [15:0] gap_row, gap_col;
    logic prev_valid, start_v, ready_v, injected;
    logic [WBITS-1:0] snap;
    t = 0; exp_r = 0; exp_c = 0; gap_reads = 0; stall_left = 7;
    gap_row = '0; gap_col = '0; prev_valid = 1'b0; injected = 1'b0; snap = '0;
    first_valid_t = -1; last_hs_t = -1; done_t = -1; end_t = -1;
    done_count = 0; nwin = 0; aborted = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b1);
    @(posedge clk);
    while (t < FRAME_BUDGET) begin
      @(negedge clk);
      start_v = 1'b0;
      ready_v = 1'b1;
      if (bus.layer3_result_read_signal) begin
        if (gap_reads == 0) begin
          gap_row = bus.read_row_addr;
          gap_col = bus.read_col_addr;
        end
        gap_reads++;
      end
      if (bus.done) begin
        done_count++;
        if (done_t < 0) done_t = t;
      end
      if (!bus.busy) begin
        end_t = t;
        break;
      end
      if (bus.window_valid && !prev_valid) begin
        if (first_valid_t < 0) first_valid_t = t + 1;
        checkOutput("win_row", bus.out_row, exp_r);
        checkOutput("win_col", bus.out_col, exp_c);
        checkOutput("gap_reads", gap_reads, (exp_c == 0) ? K * K : K);
        checkOutput("gap_first_row", gap_row, exp_r);
        checkOutput("gap_first_col", gap_col, (exp_c == 0) ? 0 : exp_c + K - 1);
        gap_reads = 0;
      end
      if (mode == MODE_STALL && bus.window_valid && bus.out_row == 16'd3 &&
          bus.out_col == 16'd5 && stall_left > 0) begin
        if (stall_left == 7) begin
          snap = bus.window_data;
        end else begin
          checkWindow("stall_data", bus.window_data, snap);
          checkOutput("stall_row", bus.out_row, 3);
          checkOutput("stall_col", bus.out_col, 5);
        end
        checkOutput("stall_read_signal", bus.layer3_result_read_signal, 0);
        ready_v = 1'b0;
        stall_left--;
      end
      if (mode == MODE_RANDOM) ready_v = 1'($urandom_range(0, 1));
      if (mode == MODE_INJECT && !injected && bus.out_row == 16'd2 &&
          bus.out_col == 16'd0 && !bus.window_valid) begin
        start_v  = 1'b1;
        injected = 1'b1;
      end
      if (mode == MODE_ABORT && bus.out_row == 16'd5 && bus.out_col == 16'd4 &&
          !bus.window_valid) begin
        applyStimulus(1'b0, 1'b1);
        rst = 1'b0;
        #1;
        checkZeroOutputs("abort");
        repeat (2) @(negedge clk);
        checkZeroOutputs("abort_held");
        rst = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (bus.window_valid && ready_v) begin
        checkWindow($sformatf("window_%0d_%0d", exp_r, exp_c), bus.window_data,
                    exp_window(exp_r, exp_c));
        if (nwin < NWIN * NWIN) store[exp_r*NWIN+exp_c] = bus.window_data;
        last_hs_t = t + 1;
        nwin++;
        if (exp_c == NWIN - 1) begin
          exp_c = 0;
          exp_r++;
        end else begin
          exp_c++;
        end
      end
      prev_valid = bus.window_valid;
      applyStimulus(start_v, ready_v);
      @(posedge clk);
      t++;
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("frame_reached_end", (end_t >= 0 || aborted) ? 1 : 0, 1);
  endtask

  initial begin
    vectors[0] = '{r: 0,  c: 0,  slot: 4, exp_row: 1,  exp_col: 1};
    vectors[1] = '{r: 0,  c: 0,  slot: 0, exp_row: 0,  exp_col: 0};
    vectors[2] = '{r: 3,  c: 6,  slot: 0, exp_row: 3,  exp_col: 6};
    vectors[3] = '{r: 1,  c: 0,  slot: 8, exp_row: 3,  exp_col: 2};
    vectors[4] = '{r: 0,  c: 11, slot: 2, exp_row: 0,  exp_col: 13};
    vectors[5] = '{r: 11, c: 11, slot: 8, exp_row: 13, exp_col: 13};
    vectors[6] = '{r: 5,  c: 7,  slot: 3, exp_row: 6,  exp_col: 7};
    vectors[7] = '{r: 11, c: 0,  slot: 6, exp_row: 13, exp_col: 0};
    vectors[8] = '{r: 7,  c: 3,  slot: 5, exp_row: 8,  exp_col: 5};

    vec_count   = 0;
    miscompares = 0;
    applyStimulus(1'b0, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkZeroOutputs("reset");
    rst = 1'b1;

    $display("[TB] full frame, window_ready high");
    runFrame(MODE_FULL);
    checkOutput("full_first_valid_edge", first_valid_t, 10);
    checkOutput("full_windows", nwin, NWIN * NWIN);
    checkOutput("full_last_handshake_edge", last_hs_t, 648);
    checkOutput("full_done_edge", done_t, 648);
    checkOutput("full_done_count", done_count, 1);
    checkOutput("full_busy_low_edge", end_t, 649);
    applyVectors("full");

    $display("[TB] stall 7 cycles on window (3,5)");
    runFrame(MODE_STALL);
    checkOutput("stall_windows", nwin, NWIN * NWIN);
    checkOutput("stall_last_handshake_edge", last_hs_t, 655);
    checkOutput("stall_done_count", done_count, 1);
    checkPixel("stall_next_win_3_6_slot0", store[3*NWIN+6][DATA_W-1:0], pixel(16'd3, 16'd6));

    $display("[TB] start pulse during fill of row 2");
    runFrame(MODE_INJECT);
    checkOutput("inject_windows", nwin, NWIN * NWIN);
    checkOutput("inject_last_handshake_edge", last_hs_t, 648);
    checkOutput("inject_done_count", done_count, 1);

    $display("[TB] random window_ready");
    runFrame(MODE_RANDOM);
    checkOutput("random_windows", nwin, NWIN * NWIN);
    checkOutput("random_done_count", done_count, 1);
    applyVectors("random");

    $display("[TB] reset during slide of (5,4)");
    runFrame(MODE_ABORT);
    checkOutput("abort_windows_before_reset", nwin, 64);
    checkOutput("abort_done_count", done_count, 0);

    $display("[TB] full frame after reset");
    runFrame(MODE_FULL);
    checkOutput("rerun_first_valid_edge", first_valid_t, 10);
    checkOutput("rerun_windows", nwin, NWIN * NWIN);
    checkOutput("rerun_done_edge", done_t, 648);
    checkOutput("rerun_done_count", done_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
